// File: rtl/mem_access_unit.sv
// Memory-stage controller between execute/writeback and the LEGv8 data memory.
// Latency from accept: misaligned 1, word store 2, load 3, byte store (RMW) 4 cycles.
// Backpressure: req_ready only in IDLE (one request in flight); resp_valid is never stalled.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid / req_ready       request handshake from execute
//   req_is_store, req_size      STUR vs LDUR, word vs byte access
//   req_addr, req_wdata, req_rd byte address, store data, load destination register
//   mem_read_flag/mem_write_flag, mem_addr, mem_wdata, mem_rdata
//                               one-cycle flag interface to the synchronous data memory
//   resp_valid, resp_data, resp_rd, resp_wb_en, resp_misaligned
//                               single-cycle completion towards writeback
//
// Optional feature macro: MEM_BYTE_ACCESS_EN
//   Defined   : req_size=1 selects a little-endian byte lane; byte stores run as
//               read-modify-write through an extra MERGE state.
//   Undefined : req_size is ignored and every access is a word access.
module mem_access_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic              req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [4:0]        req_rd,
    output logic              mem_read_flag,
    output logic              mem_write_flag,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic [4:0]        resp_rd,
    output logic              resp_wb_en,
    output logic              resp_misaligned
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_RESP    = 3'd3
`ifdef MEM_BYTE_ACCESS_EN
        ,
        ST_MERGE   = 3'd4
`endif
    } state_e;

    state_e state_q, state_d;

    // Latched request fields
    logic       is_store_q, is_store_d;
    logic [4:0] rd_q, rd_d;

    // Registered memory-side and response-side outputs
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic [4:0]        resp_rd_q, resp_rd_d;
    logic              resp_wb_en_q, resp_wb_en_d;
    logic              resp_mis_q, resp_mis_d;

    logic              accept;
    logic              req_byte;        // incoming request is a byte access
    logic              req_misaligned;  // incoming word access not on a 4-byte boundary
    logic              cur_byte;        // request in flight is a byte access
    logic [DATA_W-1:0] load_val;        // value returned to writeback for a load

`ifdef MEM_BYTE_ACCESS_EN
    logic       byte_q, byte_d;
    logic [1:0] lane_q, lane_d;
    logic [7:0] wbyte_q, wbyte_d;
    logic [7:0] rdata_byte;
    logic [DATA_W-1:0] merge_val;       // captured word with the store lane replaced

    assign req_byte = req_size;
    assign cur_byte = byte_q;

    always_comb begin
        rdata_byte = mem_rdata[7:0];
        merge_val  = mem_rdata;
        case (lane_q)
            2'd0: begin
                rdata_byte      = mem_rdata[7:0];
                merge_val[7:0]  = wbyte_q;
            end
            2'd1: begin
                rdata_byte      = mem_rdata[15:8];
                merge_val[15:8] = wbyte_q;
            end
            2'd2: begin
                rdata_byte       = mem_rdata[23:16];
                merge_val[23:16] = wbyte_q;
            end
            default: begin
                rdata_byte       = mem_rdata[31:24];
                merge_val[31:24] = wbyte_q;
            end
        endcase
    end

    assign load_val = byte_q ? {{(DATA_W-8){1'b0}}, rdata_byte} : mem_rdata;
`else
    logic unused_req_size;

    assign unused_req_size = req_size;
    assign req_byte        = 1'b0;
    assign cur_byte        = 1'b0;
    assign load_val        = mem_rdata;
`endif

    // Byte accesses can never be misaligned; word accesses need addr[1:0] == 0.
    assign req_misaligned = !req_byte && (req_addr[1:0] != 2'b00);

    // Gated by rst_n so execute never sees ready while the unit is held in reset.
    assign req_ready = rst_n && (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready;

    // ------------------------------------------------------------------
    // State register (and latched request fields)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            is_store_q <= 1'b0;
            rd_q       <= '0;
`ifdef MEM_BYTE_ACCESS_EN
            byte_q     <= 1'b0;
            lane_q     <= '0;
            wbyte_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            rd_q       <= rd_d;
`ifdef MEM_BYTE_ACCESS_EN
            byte_q     <= byte_d;
            lane_q     <= lane_d;
            wbyte_q    <= wbyte_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        rd_d       = rd_q;
`ifdef MEM_BYTE_ACCESS_EN
        byte_d     = byte_q;
        lane_d     = lane_q;
        wbyte_d    = wbyte_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    is_store_d = req_is_store;
                    rd_d       = req_rd;
`ifdef MEM_BYTE_ACCESS_EN
                    byte_d     = req_size;
                    lane_d     = req_addr[1:0];
                    wbyte_d    = req_wdata[7:0];
`endif
                    // A faulting access skips memory entirely.
                    state_d = req_misaligned ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Word stores finish after the write pulse; everything else
                // issued a read and must wait for the registered read data.
                state_d = (is_store_q && !cur_byte) ? ST_RESP : ST_CAPTURE;
            end
            ST_CAPTURE: begin
`ifdef MEM_BYTE_ACCESS_EN
                state_d = is_store_q ? ST_MERGE : ST_RESP;
`else
                state_d = ST_RESP;
`endif
            end
`ifdef MEM_BYTE_ACCESS_EN
            ST_MERGE: begin
                state_d = ST_RESP;
            end
`endif
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: next values of the registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        resp_rd_d    = resp_rd_q;
        resp_wb_en_d = resp_wb_en_q;
        resp_mis_d   = resp_mis_q;

        // Memory side: flags are asserted for the cycle the FSM sits in
        // ISSUE (read or word write) or MERGE (byte write-back).
        if (state_q == ST_IDLE && state_d == ST_ISSUE) begin
            mem_addr_d = req_addr[ADDR_W-1:2];
            if (req_is_store && !req_byte) begin
                mem_write_d = 1'b1;
                mem_wdata_d = req_wdata;
            end else begin
                // Loads, and the read half of a byte store.
                mem_read_d = 1'b1;
            end
        end
`ifdef MEM_BYTE_ACCESS_EN
        if (state_q == ST_CAPTURE && state_d == ST_MERGE) begin
            mem_write_d = 1'b1;
            mem_wdata_d = merge_val;
        end
`endif

        // Response side: updated only on entry to RESP so the data fields
        // hold steady between completions.
        if (state_d == ST_RESP) begin
            resp_valid_d = 1'b1;
            if (state_q == ST_IDLE) begin
                resp_data_d  = '0;
                resp_rd_d    = req_rd;
                resp_wb_en_d = 1'b0;
                resp_mis_d   = 1'b1;
            end else begin
                // Loads only reach RESP from CAPTURE, where mem_rdata is valid.
                resp_data_d  = is_store_q ? '0 : load_val;
                resp_rd_d    = rd_q;
                resp_wb_en_d = !is_store_q;
                resp_mis_d   = 1'b0;
            end
        end
    end

    // Output registers; reset drops any pending flag immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_rd_q    <= '0;
            resp_wb_en_q <= 1'b0;
            resp_mis_q   <= 1'b0;
        end else begin
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_rd_q    <= resp_rd_d;
            resp_wb_en_q <= resp_wb_en_d;
            resp_mis_q   <= resp_mis_d;
        end
    end

    assign mem_read_flag   = mem_read_q;
    assign mem_write_flag  = mem_write_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;
    assign resp_valid      = resp_valid_q;
    assign resp_data       = resp_data_q;
    assign resp_rd         = resp_rd_q;
    assign resp_wb_en      = resp_wb_en_q;
    assign resp_misaligned = resp_mis_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed steps followed by random
// requests, checked against a word-array reference model of the data memory.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_mem_access_unit;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
`ifdef MEM_BYTE_ACCESS_EN
    localparam bit BYTE_EN = 1'b1;
`else
    localparam bit BYTE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic        req_size = 1'b0;
    logic [9:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        mem_read_flag;
    logic        mem_write_flag;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_wb_en;
    logic        resp_misaligned;

    int n_checks = 0;
    int n_errors = 0;
    int unsigned cyc_cnt = 0;
    int unsigned acc_cyc = 0;

    logic [31:0] tb_mem  [256];  // data memory attached to the DUT
    logic [31:0] ref_mem [256];  // expected architectural memory contents

    mem_access_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_is_store    (req_is_store),
        .req_size        (req_size),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_rd          (req_rd),
        .mem_read_flag   (mem_read_flag),
        .mem_write_flag  (mem_write_flag),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .resp_valid      (resp_valid),
        .resp_data       (resp_data),
        .resp_rd         (resp_rd),
        .resp_wb_en      (resp_wb_en),
        .resp_misaligned (resp_misaligned)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Synchronous data memory: one-cycle registered read.
    initial begin
        for (int i = 0; i < 256; i++) tb_mem[i] <= 32'(i);
    end
    always @(posedge clk) begin
        if (mem_read_flag)  mem_rdata <= tb_mem[mem_addr];
        if (mem_write_flag) tb_mem[mem_addr] <= mem_wdata;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request, watch every cycle until the response, and compare
    // against the reference model. Entered and left on a falling edge with
    // the unit idle. hold=1 leaves req_valid asserted after the accept.
    task automatic run_req(input string tag, input bit st, input bit sz,
                           input logic [9:0] a, input logic [31:0] wd,
                           input logic [4:0] rd, input bit hold);
        bit          byte_op, mis;
        int          lat, exp_rd, exp_wr, n_rd, n_wr, n_both, n_rdy, got_k, waitc, sh;
        logic [7:0]  widx, seen_addr;
        logic [31:0] old_word, exp_wdata, exp_data, seen_wdata;

        byte_op  = BYTE_EN && sz;
        mis      = !byte_op && (a[1:0] != 2'b00);
        widx     = a[9:2];
        old_word = ref_mem[widx];
        sh       = 8 * int'(a[1:0]);
        lat      = mis ? 1 : (st ? (byte_op ? 4 : 2) : 3);
        exp_rd   = (mis || (st && !byte_op)) ? 0 : 1;
        exp_wr   = (!mis && st) ? 1 : 0;
        if (st && byte_op)
            exp_wdata = (old_word & ~(32'hFF << sh)) | ({24'h0, wd[7:0]} << sh);
        else
            exp_wdata = wd;
        if (st || mis)    exp_data = 32'h0;
        else if (byte_op) exp_data = (old_word >> sh) & 32'hFF;
        else              exp_data = old_word;
        if (st && !mis) ref_mem[widx] = exp_wdata;

        req_valid    = 1'b1;
        req_is_store = st;
        req_size     = sz;
        req_addr     = a;
        req_wdata    = wd;
        req_rd       = rd;
        waitc = 0;
        while (req_ready !== 1'b1 && waitc < 16) begin
            @(negedge clk);
            waitc++;
        end
        check({tag, "_ready_before_accept"}, 32'(req_ready), 32'h1);
        if (req_ready !== 1'b1) begin
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        acc_cyc = cyc_cnt;
        if (!hold) req_valid = 1'b0;

        n_rd = 0; n_wr = 0; n_both = 0; n_rdy = 0; got_k = 0;
        seen_addr = '0; seen_wdata = '0;
        for (int k = 1; k <= 8 && got_k == 0; k++) begin
            if (k > 1) @(negedge clk);
            if (mem_read_flag === 1'b1) begin
                n_rd++;
                seen_addr = mem_addr;
            end
            if (mem_write_flag === 1'b1) begin
                n_wr++;
                seen_addr  = mem_addr;
                seen_wdata = mem_wdata;
            end
            if (mem_read_flag === 1'b1 && mem_write_flag === 1'b1) n_both++;
            if (req_ready !== 1'b0) n_rdy++;
            if (resp_valid === 1'b1) got_k = k;
        end

        check({tag, "_latency"},      32'(got_k),  32'(lat));
        check({tag, "_read_pulses"},  32'(n_rd),   32'(exp_rd));
        check({tag, "_write_pulses"}, 32'(n_wr),   32'(exp_wr));
        check({tag, "_flags_both"},   32'(n_both), 32'h0);
        check({tag, "_ready_busy"},   32'(n_rdy),  32'h0);
        if (!mis) check({tag, "_mem_addr"}, 32'(seen_addr), 32'(widx));
        if (exp_wr != 0) check({tag, "_mem_wdata"}, seen_wdata, exp_wdata);
        if (got_k != 0) begin
            check({tag, "_resp_data"}, resp_data, exp_data);
            check({tag, "_resp_rd"},   32'(resp_rd), 32'(rd));
            check({tag, "_resp_wb_en"}, 32'(resp_wb_en), 32'(!st && !mis));
            check({tag, "_resp_mis"},  32'(resp_misaligned), 32'(mis));
        end
        @(negedge clk);
        check({tag, "_resp_pulse_end"}, 32'(resp_valid), 32'h0);
        check({tag, "_ready_after"},    32'(req_ready),  32'h1);
        check({tag, "_resp_data_hold"}, resp_data, exp_data);
    endtask

    initial begin
        int unsigned acc_t [3];
        logic [9:0]  ra;

        for (int i = 0; i < 256; i++) ref_mem[i] = 32'(i);

        // Reset state
        #12;
        check("rst_req_ready",  32'(req_ready),       32'h0);
        check("rst_read_flag",  32'(mem_read_flag),   32'h0);
        check("rst_write_flag", 32'(mem_write_flag),  32'h0);
        check("rst_mem_addr",   32'(mem_addr),        32'h0);
        check("rst_mem_wdata",  mem_wdata,            32'h0);
        check("rst_resp_valid", 32'(resp_valid),      32'h0);
        check("rst_resp_data",  resp_data,            32'h0);
        check("rst_resp_rd",    32'(resp_rd),         32'h0);
        check("rst_resp_wb_en", 32'(resp_wb_en),      32'h0);
        check("rst_resp_mis",   32'(resp_misaligned), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'h1);

        // Word load of word 5
        run_req("ld_014", 1'b0, 1'b0, 10'h014, 32'h0, 5'd3, 1'b0);

        // Store to the top word, then read it back
        run_req("st_3fc", 1'b1, 1'b0, 10'h3FC, 32'hDEADBEEF, 5'd7, 1'b0);
        run_req("ld_3fc", 1'b0, 1'b0, 10'h3FC, 32'h0, 5'd9, 1'b0);

        // Misaligned word load
        run_req("ld_006_mis", 1'b0, 1'b0, 10'h006, 32'h0, 5'd4, 1'b0);

        // Three loads with req_valid held high throughout
        run_req("b2b_0", 1'b0, 1'b0, 10'h000, 32'h0, 5'd1, 1'b1);
        acc_t[0] = acc_cyc;
        run_req("b2b_1", 1'b0, 1'b0, 10'h004, 32'h0, 5'd2, 1'b1);
        acc_t[1] = acc_cyc;
        run_req("b2b_2", 1'b0, 1'b0, 10'h008, 32'h0, 5'd3, 1'b0);
        acc_t[2] = acc_cyc;
        check("b2b_spacing_01", acc_t[1] - acc_t[0], 32'd4);
        check("b2b_spacing_12", acc_t[2] - acc_t[1], 32'd4);

        // Reset during the ISSUE cycle of a store to word 16
        req_valid    = 1'b1;
        req_is_store = 1'b1;
        req_size     = 1'b0;
        req_addr     = 10'h040;
        req_wdata    = 32'h12345678;
        req_rd       = 5'd0;
        @(negedge clk);
        req_valid = 1'b0;
        check("rstmid_issue_wflag", 32'(mem_write_flag), 32'h1);
        check("rstmid_issue_addr",  32'(mem_addr),       32'h10);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_wflag_drop", 32'(mem_write_flag), 32'h0);
        check("rstmid_ready_low",  32'(req_ready),      32'h0);
        check("rstmid_no_resp_0",  32'(resp_valid),     32'h0);
        @(negedge clk);
        check("rstmid_no_resp_1",  32'(resp_valid),     32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_ready_after", 32'(req_ready),  32'h1);
        check("rstmid_no_resp_2",   32'(resp_valid), 32'h0);
        run_req("rstmid_ld_old", 1'b0, 1'b0, 10'h040, 32'h0, 5'd5, 1'b0);

`ifdef MEM_BYTE_ACCESS_EN
        // Byte store into lane 1 of word 2, then word and byte reads
        run_req("bst_009", 1'b1, 1'b1, 10'h009, 32'h000000AB, 5'd0, 1'b0);
        check("bst_model_word2", ref_mem[2], 32'h0000AB02);
        run_req("ld_008_after_bst", 1'b0, 1'b0, 10'h008, 32'h0, 5'd6, 1'b0);
        run_req("bld_009", 1'b0, 1'b1, 10'h009, 32'h0, 5'd8, 1'b0);
`endif

        // Random mix of loads and stores, aligned and misaligned
        for (int n = 0; n < 40; n++) begin
            ra = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 2) != 0) ra[1:0] = 2'b00;
            run_req($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ra, $urandom, 5'($urandom_range(0, 31)), 1'b0);
        end

        // Final sweep: every word read back must match the model
        for (int w = 0; w < 256; w += 37) begin
            run_req($sformatf("sweep%0d", w), 1'b0, 1'b0, 10'(w * 4), 32'h0, 5'd31, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory-stage controller that sits directly upstream of the LEGv8 data memory. It accepts one load or store request at a time from the execute stage over a valid/ready handshake and converts the byte address to a word address. It drives the memory's one-cycle read/write flag interface, absorbs the one-cycle synchronous read latency, and returns a single-cycle response to writeback. Misaligned word accesses are flagged and never reach memory.

Parameters:
DATA_W, 32, data word width; must match the data memory.
ADDR_W, 10, byte-address width; the word address is bits [ADDR_W-1:2], 8 bits, 256 words.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  execute stage presents a request
req_ready  output  1  unit can accept; high only in IDLE, 0 while rst_n low
req_is_store  input  1  1 = STUR, 0 = LDUR
req_size  input  1  0 = word, 1 = byte; ignored without MEM_BYTE_ACCESS_EN
req_addr  input  ADDR_W  byte address
req_wdata  input  DATA_W  store data
req_rd  input  5  load destination register
mem_read_flag  output  1  to data memory read enable
mem_write_flag  output  1  to data memory write enable
mem_addr  output  8  to data memory word address
mem_wdata  output  DATA_W  to data memory write data
mem_rdata  input  DATA_W  from data memory registered read data
resp_valid  output  1  one-cycle completion pulse
resp_data  output  DATA_W  load result; 0 for stores and faults
resp_rd  output  5  echoed req_rd
resp_wb_en  output  1  register write enable: load and not misaligned
resp_misaligned  output  1  alignment fault

Behaviour:
- One clock, clk. Asynchronous active-low reset rst_n.
- Reset: state IDLE. All registered outputs are 0: mem_* flags, mem_addr, mem_wdata, resp_*.
- Reset mid-operation aborts the request. Any asserted mem flag drops immediately, and no response is produced.
- All memory-side outputs are registered. Each flag is high for exactly one cycle per access.
- Accept: at a rising edge with req_valid && req_ready. The unit latches is_store, size, addr, wdata, and rd. req_ready is then low until the unit returns to IDLE.
- Misaligned: a word access with addr[1:0] != 0 goes IDLE -> RESP. No mem flag is raised. The response is resp_misaligned=1, resp_wb_en=0, resp_data=0.
- Store path is IDLE -> ISSUE -> RESP -> IDLE.
  - ISSUE: mem_write_flag=1, mem_addr=addr[9:2], mem_wdata=wdata.
  - RESP: resp_valid=1, resp_wb_en=0.
- Load path is IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.
  - ISSUE: mem_read_flag=1.
  - CAPTURE: mem_rdata is valid; it is registered into resp_data at the end of the cycle.
  - RESP: resp_valid=1, resp_wb_en=1, resp_rd=rd.
- Latency from the accept edge:
  - store: resp_valid high 2 cycles later;
  - load: resp_valid high 3 cycles later;
  - misaligned: resp_valid high 1 cycle later.
- Back-to-back: req_ready rises in the cycle after RESP (IDLE). There is no overlap, so the store-then-load ordering is inherently coherent.
- resp_valid has no backpressure; writeback always accepts. resp_data, resp_rd, and resp_wb_en hold their values until the next RESP. resp_valid returns to 0.
- mem_read_flag and mem_write_flag are never high in the same cycle.

Optional Feature:
MEM_BYTE_ACCESS_EN
- Defined: req_size=1 selects a byte access, with little-endian lanes (lane = addr[1:0], lane 0 = bits 7:0). Byte accesses are never misaligned.
- Byte load follows the load path. resp_data is the selected byte, zero-extended.
- Byte store is a read-modify-write: IDLE -> ISSUE(read) -> CAPTURE -> MERGE -> RESP -> IDLE.
  - MERGE: mem_write_flag=1, mem_wdata = captured word with the selected lane replaced by wdata[7:0].
  - resp_valid comes 4 cycles after accept.
- Not defined: req_size is ignored, every access is a word access, and the MERGE state does not exist.

Test Plan:
- Bench memory model is preloaded with word i = i.
- Word load, addr 0x014, rd 3 -> mem_read_flag 1 cycle at mem_addr 0x05; 3 cycles after accept: resp_valid=1, resp_data=0x00000005, resp_rd=3, resp_wb_en=1.
- Store 0xDEADBEEF to addr 0x3FC, then load 0x3FC -> one mem_write_flag pulse at mem_addr 0xFF; load returns 0xDEADBEEF; req_ready is low for 2 cycles after the store accept.
- Load at addr 0x006 -> no mem flags; next cycle resp_valid=1, resp_misaligned=1, resp_wb_en=0, resp_data=0.
- req_valid held high for 3 loads (addr 0x000, 0x004, 0x008) -> accepts spaced 4 cycles apart; responses are 0, 1, 2 in order; read and write flags are never both high.
- Deassert rst_n during ISSUE of a store -> mem_write_flag drops immediately; no resp_valid; after release, req_ready=1 and the next load at that word returns the old value.
- With MEM_BYTE_ACCESS_EN: byte store 0xAB at addr 0x009 (word 2 = 0x00000002), then word load 0x008 -> write data 0x0000AB02; resp 4 cycles after accept; the load returns 0x0000AB02.
